fp_mant_mul: RTL

FP_MANT_MUL -- requirements
Module: fp_mant_mul

---
 rtl/fp_mul_pkg.sv | 15 +
 rtl/fp_unpack.sv | 19 +
 rtl/fp_mant_mul.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fp_mul_pkg.sv
// Shared definitions for the single-precision multiplier pipeline
// (mantissa multiply, normalise and round stages).
package fp_mul_pkg;

    localparam int EW   = 8;
    localparam int MW   = 23;
    localparam int BIAS = 127;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fp_unpack.sv
// Splits an IEEE-754 word into sign, exponent and significand (hidden bit set);
// flags a zero exponent so the multiplier can flush zeros and denormals.
module fp_unpack #(
    parameter int EXP_W = fp_mul_pkg::EW,
    parameter int MAN_W = fp_mul_pkg::MW
) (
    input  logic [EXP_W+MAN_W:0] x_i,
    output logic                 sign_o,
    output logic [EXP_W-1:0]     exp_o,
    output logic [MAN_W:0]       sig_o,
    output logic                 zero_o
);

    assign sign_o = x_i[EXP_W+MAN_W];
    assign exp_o  = x_i[EXP_W+MAN_W-1:MAN_W];
    assign sig_o  = {1'b1, x_i[MAN_W-1:0]};
    assign zero_o = (exp_o == '0);

endmodule

// File: rtl/fp_mant_mul.sv
// Sequential shift-add significand multiplier: one multiplier bit per cycle,
// with the biased exponent sum and sign produced alongside for the normaliser.
module fp_mant_mul #(
    parameter int BIAS = fp_mul_pkg::BIAS,
    parameter int MW   = fp_mul_pkg::MW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [fp_mul_pkg::EW+MW:0]  a,
    input  logic [fp_mul_pkg::EW+MW:0]  b,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [MW:0]                 c_m,
    output logic [fp_mul_pkg::EW-1:0]   c_e,
    output logic                        c_s,
    output logic                        c_ovf,
    output logic                        c_unf,
    output logic                        out_valid,
    input  logic                        out_ready
);

    import fp_mul_pkg::*;

    localparam int SW = MW + 1;
    localparam int PW = 2 * SW;
    localparam int CW = $clog2(SW);
    localparam int XW = EW + 2;

    localparam logic signed [XW-1:0] EXP_ADJ   = XW'(BIAS - 1);
    localparam logic signed [XW-1:0] EXP_MAX   = XW'((1 << EW) - 1);
    localparam logic signed [XW-1:0] EXP_MIN   = XW'(1);
    localparam logic [CW-1:0]        LAST_STEP = CW'(SW - 1);

    logic          a_sign, b_sign, a_zero, b_zero;
    logic [EW-1:0] a_exp, b_exp;
    logic [MW:0]   a_sig, b_sig;

    fp_unpack #(.EXP_W(EW), .MAN_W(MW)) u_unpack_a (
        .x_i    (a),
        .sign_o (a_sign),
        .exp_o  (a_exp),
        .sig_o  (a_sig),
        .zero_o (a_zero)
    );

    fp_unpack #(.EXP_W(EW), .MAN_W(MW)) u_unpack_b (
        .x_i    (b),
        .sign_o (b_sign),
        .exp_o  (b_exp),
        .sig_o  (b_sig),
        .zero_o (b_zero)
    );

    state_e        state_q, state_d;
    logic          sa_q, sa_d, sb_q, sb_d;
    logic [EW-1:0] ea_q, ea_d, eb_q, eb_d;
    logic [MW:0]   ma_q, ma_d, mb_q, mb_d;
    logic          zero_q, zero_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        zero_d  = zero_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sa_d    = a_sign;
                    sb_d    = b_sign;
                    ea_d    = a_exp;
                    eb_d    = b_exp;
                    ma_d    = a_sig;
                    mb_d    = b_sig;
                    zero_d  = a_zero | b_zero;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                if (zero_q) begin
                    state_d = ST_DONE;
                end else begin
                    if (mb_q[cnt_q]) begin
                        acc_d = acc_q + (PW'(ma_q) << cnt_q);
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset leaves the operands as all-zero words, so the zero flag starts set
    // and the c_* outputs read as zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            zero_q  <= 1'b1;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            zero_q  <= zero_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bias is removed minus one: the normaliser decrements when c_m[MSB] is clear.
    logic signed [XW-1:0] exp_sum;
    assign exp_sum = $signed(XW'(ea_q)) + $signed(XW'(eb_q)) - EXP_ADJ;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign c_m       = acc_q[PW-1 -: SW];
    assign c_s       = sa_q ^ sb_q;
    assign c_e       = zero_q ? '0 : exp_sum[EW-1:0];
    assign c_ovf     = !zero_q && (exp_sum > EXP_MAX);
    assign c_unf     = !zero_q && (exp_sum < EXP_MIN);

endmodule
